control_multiciclo: RTL and testbench

//  Moore FSM that sequences the multicycle RV32I datapath: PC, instruction/data memory, register bank, ALU.

---
 rtl/control_multiciclo_pkg.sv | 183 ++++++++++++++++++
 rtl/control_multiciclo_alu_decoder.sv | 35 +++
 rtl/control_multiciclo.sv | 96 +++++++++
 tb/tb_control_multiciclo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_multiciclo_pkg.sv
// Shared definitions for the multicycle RV32I control unit: opcodes, FSM
// states, ALU and mux-select codes, and the per-state control word.
package control_multiciclo_pkg;

  localparam int OP_W     = 7;
  localparam int ALUCTL_W = 3;

  // RV32I opcodes handled by this controller
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // FSM state encodings, also exported on the debug port
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // Coarse ALU operation requested by the FSM; FUNCT defers to the instruction
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // ALU control codes seen by the datapath
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  // ALU operand B mux
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format selector
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Everything the FSM registers for a given state
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    aluop_t     alu_op;
  } ctrl_t;

  // Moore output table: control word associated with each state
  function automatic ctrl_t ctrl_for(state_t s);
    ctrl_t c;
    c = '0;
    c.alu_op = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.result_src = RES_ALUOUT;
        c.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.result_src = RES_ALUOUT;
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_REG;
        c.alu_src_b  = SRCB_REG;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // True for the opcodes this controller can execute
  function automatic logic is_supported(logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

  // Successor of DECODE, chosen by opcode; unknown opcodes go back to FETCH
  function automatic state_t decode_next(logic [6:0] op);
    state_t n;
    case (op)
      OP_LW, OP_SW: n = S_MEMADR;
      OP_R:         n = S_EXECUTER;
      OP_I:         n = S_EXECUTEI;
      OP_BEQ:       n = S_BEQ;
      OP_JAL:       n = S_JAL;
      default:      n = S_FETCH;
    endcase
    return n;
  endfunction

  // Immediate format implied by the opcode
  function automatic logic [1:0] imm_src_for(logic [6:0] op);
    logic [1:0] r;
    case (op)
      OP_SW:   r = IMM_S;
      OP_BEQ:  r = IMM_B;
      OP_JAL:  r = IMM_J;
      default: r = IMM_I;
    endcase
    return r;
  endfunction

  // Encodings beyond the last defined state are never legitimately reached
  function automatic logic is_valid_state(logic [3:0] s);
    return s <= 4'(S_JAL);
  endfunction

endpackage

// File: rtl/control_multiciclo_alu_decoder.sv
// ALU decoder: turns the FSM's coarse ALU request plus the instruction's
// funct fields into the datapath ALU control code.
module alu_decoder
  import control_multiciclo_pkg::*;
#(
  parameter int ALUCTL_W = 3
) (
  input  aluop_t              alu_op,
  input  logic [2:0]          funct3,
  input  logic                op_b5,
  input  logic                funct7b5,
  output logic [ALUCTL_W-1:0] alu_control
);

  // Subtract only for R-type (op[5]=1) with funct7b5 set; addi is never sub
  always_comb begin
    alu_control = ALUCTL_W'(ALU_ADD);
    case (alu_op)
      ALUOP_ADD: alu_control = ALUCTL_W'(ALU_ADD);
      ALUOP_SUB: alu_control = ALUCTL_W'(ALU_SUB);
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op_b5 & funct7b5) ? ALUCTL_W'(ALU_SUB)
                                                    : ALUCTL_W'(ALU_ADD);
          3'b010:  alu_control = ALUCTL_W'(ALU_SLT);
          3'b110:  alu_control = ALUCTL_W'(ALU_OR);
          3'b111:  alu_control = ALUCTL_W'(ALU_AND);
          default: alu_control = ALUCTL_W'(ALU_ADD);
        endcase
      end
      default: alu_control = ALUCTL_W'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch, decode and the
// execute/memory/writeback steps of lw, sw, R-type, I-type ALU, beq and jal.
module control_multiciclo
  import control_multiciclo_pkg::*;
#(
  parameter int OP_W     = 7,
  parameter int ALUCTL_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     op,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                zero,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          imm_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                reg_write,
  output logic                illegal,
  output logic [3:0]          state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;
  logic   write_ok;

  // Next-state logic; any unexpected encoding recovers to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = decode_next(op);
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // State and control word registered together so outputs are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_for(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d);
    end
  end

  // Strobes die the instant reset asserts, and stay dead in a corrupt state
  assign write_ok = rst_n & is_valid_state(state_q);

  assign pc_write  = write_ok & (ctrl_q.pc_update | (ctrl_q.branch & zero));
  assign ir_write  = write_ok & ctrl_q.ir_write;
  assign mem_write = write_ok & ctrl_q.mem_write;
  assign reg_write = write_ok & ctrl_q.reg_write;

  assign adr_src    = ctrl_q.adr_src;
  assign result_src = ctrl_q.result_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;

  // The opcode is only stable once the IR is loaded, so these follow op live
  assign imm_src = imm_src_for(op);
  assign illegal = (state_q == S_DECODE) & ~is_supported(op);
  assign state   = state_q;

  alu_decoder #(
    .ALUCTL_W (ALUCTL_W)
  ) u_alu_decoder (
    .alu_op      (ctrl_q.alu_op),
    .funct3      (funct3),
    .op_b5       (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for the multicycle control unit: walks each instruction
// class through its state sequence and checks strobes and selects.
module tb_control_multiciclo;
  import control_multiciclo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  control_multiciclo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .reg_write   (reg_write),
    .illegal     (illegal),
    .state       (state)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case something stalls the sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    @(negedge clk); @(negedge clk);
    total_cnt++;
    if (state !== 4'd0) $display("[TB] FAIL rst_state got=%0d exp=0", state); else pass_cnt++;
    total_cnt++;
    if ({pc_write, ir_write, mem_write, reg_write} !== 4'b0000)
      $display("[TB] FAIL rst_strobes got=%b exp=0000", {pc_write, ir_write, mem_write, reg_write});
    else pass_cnt++;
    total_cnt++;
    if ({result_src, alu_src_a, alu_src_b} !== 6'b10_00_10)
      $display("[TB] FAIL rst_selects got=%b exp=100010", {result_src, alu_src_a, alu_src_b});
    else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if ({state, ir_write, pc_write} !== {4'd0, 2'b11})
      $display("[TB] FAIL rel_fetch got=%0d/%b%b exp=0/11", state, ir_write, pc_write);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({state, alu_src_a, alu_src_b, ir_write} !== {4'd1, 2'b01, 2'b01, 1'b0})
      $display("[TB] FAIL rel_decode got=%0d/%b/%b/%b exp=1/01/01/0", state, alu_src_a, alu_src_b, ir_write);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({state, alu_control} !== {4'd6, 3'b000})
      $display("[TB] FAIL r_add got=%0d/%b exp=6/000", state, alu_control);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (state !== 4'd0) $display("[TB] FAIL r_add_ret got=%0d exp=0", state); else pass_cnt++;
  endtask

  task automatic test_lw();
    logic [3:0] seq [5];
    seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    op = 7'b0000011;
    #1;
    total_cnt++;
    if (imm_src !== 2'b00) $display("[TB] FAIL lw_imm got=%b exp=00", imm_src); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_cnt++;
      if (state !== seq[i]) $display("[TB] FAIL lw_state%0d got=%0d exp=%0d", i, state, seq[i]); else pass_cnt++;
      total_cnt++;
      if (reg_write !== (seq[i] == 4'd4))
        $display("[TB] FAIL lw_regwrite%0d got=%b exp=%b", i, reg_write, seq[i] == 4'd4);
      else pass_cnt++;
      if (seq[i] == 4'd3) begin
        total_cnt++;
        if ({adr_src, result_src, mem_write} !== 4'b1_00_0)
          $display("[TB] FAIL lw_memread got=%b exp=1000", {adr_src, result_src, mem_write});
        else pass_cnt++;
      end
      if (seq[i] == 4'd4) begin
        total_cnt++;
        if (result_src !== 2'b01) $display("[TB] FAIL lw_result got=%b exp=01", result_src); else pass_cnt++;
      end
    end
  endtask

  task automatic test_sw();
    logic [3:0] seq [4];
    seq = '{4'd1, 4'd2, 4'd5, 4'd0};
    op = 7'b0100011;
    #1;
    total_cnt++;
    if (imm_src !== 2'b01) $display("[TB] FAIL sw_imm got=%b exp=01", imm_src); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if (state !== seq[i]) $display("[TB] FAIL sw_state%0d got=%0d exp=%0d", i, state, seq[i]); else pass_cnt++;
      total_cnt++;
      if ({mem_write, reg_write} !== {seq[i] == 4'd5, 1'b0})
        $display("[TB] FAIL sw_strobes%0d got=%b%b exp=%b0", i, mem_write, reg_write, seq[i] == 4'd5);
      else pass_cnt++;
    end
  endtask

  task automatic test_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic [3:0] exec_st, input logic [1:0] exp_b,
                          input logic [2:0] exp_ctl, input string name);
    op = o; funct3 = f3; funct7b5 = f7;
    @(negedge clk);
    total_cnt++;
    if (state !== 4'd1) $display("[TB] FAIL %s_decode got=%0d exp=1", name, state); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({state, alu_src_a, alu_src_b, alu_control} !== {exec_st, 2'b10, exp_b, exp_ctl})
      $display("[TB] FAIL %s_exec got=%0d/%b/%b/%b exp=%0d/10/%b/%b", name,
               state, alu_src_a, alu_src_b, alu_control, exec_st, exp_b, exp_ctl);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({state, reg_write, result_src} !== {4'd8, 1'b1, 2'b00})
      $display("[TB] FAIL %s_wb got=%0d/%b/%b exp=8/1/00", name, state, reg_write, result_src);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (state !== 4'd0) $display("[TB] FAIL %s_ret got=%0d exp=0", name, state); else pass_cnt++;
  endtask

  task automatic test_beq(input logic z);
    op = 7'b1100011; zero = z;
    @(negedge clk);
    total_cnt++;
    if ({state, pc_write, imm_src} !== {4'd1, 1'b0, 2'b10})
      $display("[TB] FAIL beq%b_decode got=%0d/%b/%b exp=1/0/10", z, state, pc_write, imm_src);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({state, pc_write, alu_control, reg_write} !== {4'd9, z, 3'b001, 1'b0})
      $display("[TB] FAIL beq%b_exec got=%0d/%b/%b/%b exp=9/%b/001/0", z, state, pc_write, alu_control, reg_write, z);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (state !== 4'd0) $display("[TB] FAIL beq%b_ret got=%0d exp=0", z, state); else pass_cnt++;
    zero = 1'b0;
  endtask

  task automatic test_jal();
    op = 7'b1101111;
    @(negedge clk);
    total_cnt++;
    if ({state, imm_src} !== {4'd1, 2'b11}) $display("[TB] FAIL jal_decode got=%0d/%b exp=1/11", state, imm_src); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({state, pc_write, alu_src_a, alu_src_b, reg_write} !== {4'd10, 1'b1, 2'b01, 2'b10, 1'b0})
      $display("[TB] FAIL jal_exec got=%0d/%b/%b/%b/%b exp=10/1/01/10/0", state, pc_write, alu_src_a, alu_src_b, reg_write);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({state, reg_write, pc_write} !== {4'd8, 1'b1, 1'b0})
      $display("[TB] FAIL jal_wb got=%0d/%b/%b exp=8/1/0", state, reg_write, pc_write);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (state !== 4'd0) $display("[TB] FAIL jal_ret got=%0d exp=0", state); else pass_cnt++;
  endtask

  task automatic test_illegal();
    op = 7'b1111111;
    #1;
    total_cnt++;
    if (illegal !== 1'b0) $display("[TB] FAIL ill_fetch got=%b exp=0", illegal); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({state, illegal, pc_write, ir_write, mem_write, reg_write} !== {4'd1, 5'b1_0000})
      $display("[TB] FAIL ill_decode got=%0d/%b/%b%b%b%b exp=1/1/0000", state, illegal, pc_write, ir_write, mem_write, reg_write);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({state, illegal} !== {4'd0, 1'b0}) $display("[TB] FAIL ill_ret got=%0d/%b exp=0/0", state, illegal); else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    op = 7'b0100011;
    @(negedge clk); @(negedge clk); @(negedge clk);
    total_cnt++;
    if ({state, mem_write} !== {4'd5, 1'b1}) $display("[TB] FAIL mid_memwrite got=%0d/%b exp=5/1", state, mem_write); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({state, mem_write} !== {4'd0, 1'b0}) $display("[TB] FAIL mid_abort got=%0d/%b exp=0/0", state, mem_write); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if ({state, mem_write, ir_write} !== {4'd0, 2'b01})
      $display("[TB] FAIL mid_restart got=%0d/%b%b exp=0/01", state, mem_write, ir_write);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({state, mem_write} !== {4'd1, 1'b0}) $display("[TB] FAIL mid_decode got=%0d/%b exp=1/0", state, mem_write); else pass_cnt++;
  endtask

  // Scenario sequence; each test starts and ends with the FSM in FETCH
  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_alu(7'b0110011, 3'b000, 1'b1, 4'd6, 2'b00, 3'b001, "r_sub");
    test_alu(7'b0110011, 3'b111, 1'b0, 4'd6, 2'b00, 3'b010, "r_and");
    test_alu(7'b0110011, 3'b010, 1'b0, 4'd6, 2'b00, 3'b101, "r_slt");
    test_alu(7'b0010011, 3'b000, 1'b1, 4'd7, 2'b01, 3'b000, "i_addi");
    test_alu(7'b0010011, 3'b110, 1'b0, 4'd7, 2'b01, 3'b011, "i_ori");
    test_alu(7'b0010011, 3'b001, 1'b0, 4'd7, 2'b01, 3'b000, "i_other");
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal();
    test_illegal();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
